// File: rtl/pool_pkg.sv
// Shared types for the max-pool sequencer: FSM states, widths and latched config.
package pool_pkg;

  localparam int DIM_W  = 6;
  localparam int WIN_W  = 3;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } pool_ctrl_state_e;

  typedef struct packed {
    logic [DIM_W-1:0] m;
    logic [DIM_W-1:0] n;
    logic [WIN_W-1:0] p;
    logic [WIN_W-1:0] q;
  } pool_cfg_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Window/element walker: produces read and write byte addresses with adders only.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_i,
  input  logic                  step_elem_i,
  input  logic                  step_win_i,
  input  pool_cfg_t             cfg_i,
  input  logic [ADDR_WIDTH-1:0] rd_base_i,
  input  logic [ADDR_WIDTH-1:0] wr_base_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic                  last_elem_o,
  output logic                  last_win_o
);

  logic [WIN_W-1:0]      i_q, j_q;
  // Rows/columns still available beyond the current window; replaces r/c counters
  // so the last window is found without dividing M by P or N by Q.
  logic [DIM_W-1:0]      r_left_q, c_left_q;
  logic [ADDR_WIDTH-1:0] elem_q, row_q, win_q, winrow_q, rowst_q, wr_q;
  logic [ADDR_WIDTH-1:0] n_a, q_a, next_row_d, next_win_d;
  logic                  last_col, last_row;

  assign n_a        = ADDR_WIDTH'(cfg_i.n);
  assign q_a        = ADDR_WIDTH'(cfg_i.q);
  assign next_row_d = rowst_q + n_a;
  assign next_win_d = win_q + q_a;
  assign last_col   = c_left_q < DIM_W'(cfg_i.q);
  assign last_row   = r_left_q < DIM_W'(cfg_i.p);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q      <= '0;
      j_q      <= '0;
      r_left_q <= '0;
      c_left_q <= '0;
      elem_q   <= '0;
      row_q    <= '0;
      win_q    <= '0;
      winrow_q <= '0;
      rowst_q  <= '0;
      wr_q     <= '0;
    end else if (init_i) begin
      i_q      <= '0;
      j_q      <= '0;
      r_left_q <= cfg_i.m - DIM_W'(cfg_i.p);
      c_left_q <= cfg_i.n - DIM_W'(cfg_i.q);
      elem_q   <= rd_base_i;
      row_q    <= rd_base_i;
      win_q    <= rd_base_i;
      winrow_q <= rd_base_i;
      rowst_q  <= rd_base_i;
      wr_q     <= wr_base_i;
    end else if (step_win_i) begin
      i_q  <= '0;
      j_q  <= '0;
      wr_q <= wr_q + ADDR_WIDTH'(1);
      if (last_col) begin
        // rowst_q sits on the last element row of this window row, so one more N
        // lands on the first row of the next window row.
        c_left_q <= cfg_i.n - DIM_W'(cfg_i.q);
        r_left_q <= r_left_q - DIM_W'(cfg_i.p);
        elem_q   <= next_row_d;
        row_q    <= next_row_d;
        win_q    <= next_row_d;
        winrow_q <= next_row_d;
        rowst_q  <= next_row_d;
      end else begin
        c_left_q <= c_left_q - DIM_W'(cfg_i.q);
        elem_q   <= next_win_d;
        row_q    <= next_win_d;
        win_q    <= next_win_d;
        rowst_q  <= winrow_q;
      end
    end else if (step_elem_i) begin
      if (j_q == cfg_i.q - WIN_W'(1)) begin
        j_q     <= '0;
        i_q     <= i_q + WIN_W'(1);
        row_q   <= row_q + n_a;
        elem_q  <= row_q + n_a;
        rowst_q <= next_row_d;
      end else begin
        j_q    <= j_q + WIN_W'(1);
        elem_q <= elem_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign rd_addr_o   = elem_q;
  assign wr_addr_o   = wr_q;
  assign last_elem_o = (i_q == cfg_i.p - WIN_W'(1)) && (j_q == cfg_i.q - WIN_W'(1));
  assign last_win_o  = last_row && last_col;

endmodule

// File: rtl/pool_ctrl.sv
// Max-pool sequencer: one read per window element, running signed max, one write per window.
module pool_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_W      = 6,
  parameter int WIN_W      = 3,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_pool_start,
  input  logic [ADDR_WIDTH-1:0] sw_cnn_pool_rd_addr,
  input  logic [ADDR_WIDTH-1:0] sw_pool_wr_addr,
  input  logic [DIM_W-1:0]      sw_cnn_pool_rd_m,
  input  logic [DIM_W-1:0]      sw_cnn_pool_rd_n,
  input  logic [WIN_W-1:0]      sw_pool_m,
  input  logic [WIN_W-1:0]      sw_pool_n,
  output logic                  cnn_sw_busy_ind,
  output logic                  pool_done,
  output logic                  pool_err,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_gnt,
  input  logic                  rd_valid,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_gnt
);
  import pool_pkg::*;

  pool_ctrl_state_e  state_q;
  pool_cfg_t         cfg_q, sw_cfg, cfg_use;
  logic              busy_q, done_q, err_q, rd_req_q, wr_req_q, first_q;
  logic [DATA_W-1:0] max_q;
  logic              cfg_bad, start_acc, init, step_elem, step_win, last_elem, last_win;

  assign sw_cfg    = '{m: sw_cnn_pool_rd_m, n: sw_cnn_pool_rd_n, p: sw_pool_m, q: sw_pool_n};
  // The walker loads from the live inputs on the start cycle, then from the latched copy.
  assign cfg_use   = (state_q == IDLE) ? sw_cfg : cfg_q;
  assign cfg_bad   = (sw_pool_m == '0) || (sw_pool_n == '0) ||
                     (DIM_W'(sw_pool_m) > sw_cnn_pool_rd_m) ||
                     (DIM_W'(sw_pool_n) > sw_cnn_pool_rd_n);
  assign start_acc = (state_q == IDLE) && sw_pool_start;
  assign init      = start_acc && !cfg_bad;
  assign step_elem = (state_q == RD_WAIT) && rd_valid && !last_elem;
  assign step_win  = (state_q == WR_REQ) && wr_gnt && !last_win;

  pool_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_i      (init),
    .step_elem_i (step_elem),
    .step_win_i  (step_win),
    .cfg_i       (cfg_use),
    .rd_base_i   (sw_cnn_pool_rd_addr),
    .wr_base_i   (sw_pool_wr_addr),
    .rd_addr_o   (rd_addr),
    .wr_addr_o   (wr_addr),
    .last_elem_o (last_elem),
    .last_win_o  (last_win)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cfg_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      first_q  <= 1'b0;
      max_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            cfg_q <= sw_cfg;
            if (cfg_bad) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              err_q    <= 1'b0;
              busy_q   <= 1'b1;
              rd_req_q <= 1'b1;
              first_q  <= 1'b1;
              state_q  <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (rd_gnt) begin
            rd_req_q <= 1'b0;
            state_q  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_valid) begin
            first_q <= 1'b0;
            if (first_q || ($signed(rd_data) > $signed(max_q))) max_q <= rd_data;
            if (last_elem) begin
              wr_req_q <= 1'b1;
              state_q  <= WR_REQ;
            end else begin
              rd_req_q <= 1'b1;
              state_q  <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (wr_gnt) begin
            wr_req_q <= 1'b0;
            if (last_win) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              rd_req_q <= 1'b1;
              first_q  <= 1'b1;
              state_q  <= RD_REQ;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cnn_sw_busy_ind = busy_q;
  assign pool_done       = done_q;
  assign pool_err        = err_q;
  assign rd_req          = rd_req_q;
  assign wr_req          = wr_req_q;
  assign wr_data         = max_q;

endmodule

// File: tb/tb_pool_ctrl.sv
// Scoreboard bench for pool_ctrl: memory responders pop expected reads/writes as they complete.
module tb_pool_ctrl;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_pool_start;
  logic [AW-1:0] sw_cnn_pool_rd_addr, sw_pool_wr_addr;
  logic [5:0]    sw_cnn_pool_rd_m, sw_cnn_pool_rd_n;
  logic [2:0]    sw_pool_m, sw_pool_n;
  logic          cnn_sw_busy_ind, pool_done, pool_err;
  logic          rd_req, rd_gnt, rd_valid, wr_req, wr_gnt;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data, wr_data;

  always #5 clk = ~clk;

  pool_ctrl #(.ADDR_WIDTH(AW), .DIM_W(6), .WIN_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sw_pool_start(sw_pool_start),
    .sw_cnn_pool_rd_addr(sw_cnn_pool_rd_addr), .sw_pool_wr_addr(sw_pool_wr_addr),
    .sw_cnn_pool_rd_m(sw_cnn_pool_rd_m), .sw_cnn_pool_rd_n(sw_cnn_pool_rd_n),
    .sw_pool_m(sw_pool_m), .sw_pool_n(sw_pool_n),
    .cnn_sw_busy_ind(cnn_sw_busy_ind), .pool_done(pool_done), .pool_err(pool_err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt)
  );

  logic [7:0]    mem [0:4095];
  logic [AW-1:0] exp_rd_q [$];
  logic [AW+7:0] exp_wr_q [$];
  int tests = 0, fails = 0;
  int n_rd = 0, n_wr = 0, n_done = 0;
  bit stall_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (pool_done === 1'b1) n_done++;

  // Read port: grants after a random stall, returns data after a random delay,
  // and injects stray rd_valid pulses while no read is outstanding.
  initial begin : rd_resp
    int stall, pend;
    logic req_d;
    logic [AW-1:0] addr_d;
    logic [7:0] pdata;
    stall = -1; pend = -1; req_d = 1'b0; addr_d = '0; pdata = '0;
    rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      rd_valid = 1'b0;
      if (!rst_n) begin
        rd_gnt = 1'b0; stall = -1; pend = -1; req_d = 1'b0;
      end else begin
        if (rd_gnt && req_d) begin
          n_rd++;
          if (exp_rd_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL rd_extra: read of %0h with nothing expected", addr_d);
          end else chk("rd_addr", addr_d, exp_rd_q.pop_front());
          pdata  = mem[addr_d];
          pend   = stall_en ? int'($urandom_range(0, 4)) : 0;
          rd_gnt = 1'b0;
          stall  = -1;
        end else if (req_d && rd_req) chk("rd_addr_hold", rd_addr, addr_d);
        if (pend == 0) begin
          rd_valid = 1'b1; rd_data = pdata; pend = -1;
        end else if (pend > 0) pend--;
        else if (stall_en && $urandom_range(0, 3) == 0) begin
          rd_valid = 1'b1; rd_data = 8'h7F;
        end
        if (rd_req) begin
          if (stall < 0) stall = stall_en ? int'($urandom_range(0, 5)) : 0;
          if (stall == 0) rd_gnt = 1'b1; else stall--;
        end
        req_d = rd_req; addr_d = rd_addr;
      end
    end
  end

  initial begin : wr_resp
    int stall;
    logic req_d;
    logic [AW-1:0] a_d;
    logic [7:0] d_d;
    logic [AW+7:0] e;
    stall = -1; req_d = 1'b0; a_d = '0; d_d = '0;
    wr_gnt = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_gnt = 1'b0; stall = -1; req_d = 1'b0;
      end else begin
        if (wr_gnt && req_d) begin
          n_wr++;
          if (exp_wr_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL wr_extra: write %0h <= %0h with nothing expected", a_d, d_d);
          end else begin
            e = exp_wr_q.pop_front();
            chk("wr_addr", a_d, e[AW+7:8]);
            chk("wr_data", d_d, e[7:0]);
          end
          wr_gnt = 1'b0;
          stall  = -1;
        end else if (req_d && wr_req) begin
          chk("wr_addr_hold", wr_addr, a_d);
          chk("wr_data_hold", wr_data, d_d);
        end
        if (wr_req) begin
          if (stall < 0) stall = stall_en ? int'($urandom_range(0, 5)) : 0;
          if (stall == 0) wr_gnt = 1'b1; else stall--;
        end
        req_d = wr_req; a_d = wr_addr; d_d = wr_data;
      end
    end
  end

  // Reference traversal written directly from the address formula.
  task automatic expect_pool(input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                             input int m, input int n, input int p, input int q, input bit with_wr);
    for (int r = 0; r < m / p; r++) begin
      for (int c = 0; c < n / q; c++) begin
        logic [7:0] mx;
        logic [AW-1:0] a;
        mx = '0;
        for (int i = 0; i < p; i++) begin
          for (int j = 0; j < q; j++) begin
            a = rb + AW'((r * p + i) * n + c * q + j);
            exp_rd_q.push_back(a);
            if ((i == 0 && j == 0) || $signed(mem[a]) > $signed(mx)) mx = mem[a];
          end
        end
        if (with_wr) exp_wr_q.push_back({wb + AW'(r * (n / q) + c), mx});
      end
    end
  endtask

  task automatic issue_start(input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                             input int m, input int n, input int p, input int q);
    @(negedge clk);
    sw_cnn_pool_rd_addr = rb; sw_pool_wr_addr = wb;
    sw_cnn_pool_rd_m = 6'(m); sw_cnn_pool_rd_n = 6'(n);
    sw_pool_m = 3'(p); sw_pool_n = 3'(q);
    sw_pool_start = 1'b1;
    @(negedge clk);
    sw_pool_start = 1'b0;
    // A legal but different config: any leak of these into the run shows up.
    sw_cnn_pool_rd_addr = ~rb; sw_pool_wr_addr = ~wb;
    sw_cnn_pool_rd_m = 6'd63; sw_cnn_pool_rd_n = 6'd63;
    sw_pool_m = 3'd1; sw_pool_n = 3'd1;
  endtask

  task automatic run(input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                     input int m, input int n, input int p, input int q,
                     input bit bad, input bit poke, input int nrd, input int nwr);
    int cyc, busy_bad, d0, r0, w0, quiet;
    bit got;
    cyc = 0; busy_bad = 0; got = 1'b0; quiet = 0;
    d0 = n_done; r0 = n_rd; w0 = n_wr;
    issue_start(rb, wb, m, n, p, q);
    if (bad) begin
      chk("err_done", pool_done, 1);
      chk("err_flag", pool_err, 1);
      chk("err_busy", cnn_sw_busy_ind, 0);
      repeat (4) begin
        @(negedge clk);
        if (rd_req || wr_req || cnn_sw_busy_ind || pool_done) quiet++;
      end
      chk("err_quiet", quiet, 0);
      chk("err_sticky", pool_err, 1);
      chk("err_done_count", n_done - d0, 1);
      return;
    end
    chk("busy_start", cnn_sw_busy_ind, 1);
    chk("err_cleared", pool_err, 0);
    while (cyc < 3000) begin
      if (pool_done) begin
        got = 1'b1;
        break;
      end
      if (!cnn_sw_busy_ind) busy_bad++;
      sw_pool_start = poke && (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    sw_pool_start = 1'b0;
    chk("done_seen", got, 1);
    chk("busy_during", busy_bad, 0);
    chk("busy_at_done", cnn_sw_busy_ind, 0);
    @(negedge clk);
    chk("done_pulse", pool_done, 0);
    @(negedge clk);
    chk("done_count", n_done - d0, 1);
    chk("rd_count", n_rd - r0, nrd);
    chk("wr_count", n_wr - w0, nwr);
    chk("rd_left", exp_rd_q.size(), 0);
    chk("wr_left", exp_wr_q.size(), 0);
  endtask

  task automatic expect_basic();
    expect_pool(12'h100, 12'h200, 4, 4, 2, 2, 1'b0);
    exp_wr_q.push_back({12'h200, 8'h05});
    exp_wr_q.push_back({12'h201, 8'h07});
    exp_wr_q.push_back({12'h202, 8'h0D});
    exp_wr_q.push_back({12'h203, 8'h0F});
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin : main
    int d0;
    sw_pool_start = 1'b0; sw_cnn_pool_rd_addr = '0; sw_pool_wr_addr = '0;
    sw_cnn_pool_rd_m = '0; sw_cnn_pool_rd_n = '0; sw_pool_m = '0; sw_pool_n = '0;
    for (int k = 0; k < 4096; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {cnn_sw_busy_ind, pool_done, pool_err, rd_req, wr_req}, 0);
    chk("reset_addr", {rd_addr, wr_addr}, 0);
    chk("reset_wdata", wr_data, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) mem[12'h100 + k] = 8'(k);
    expect_basic();
    run(12'h100, 12'h200, 4, 4, 2, 2, 1'b0, 1'b0, 16, 4);

    mem[12'h300] = 8'hFB; mem[12'h301] = 8'hFF; mem[12'h302] = 8'h80; mem[12'h303] = 8'h80;
    mem[12'h304] = 8'h80; mem[12'h305] = 8'hFD; mem[12'h306] = 8'h80; mem[12'h307] = 8'h80;
    expect_pool(12'h300, 12'h380, 2, 4, 2, 2, 1'b0);
    exp_wr_q.push_back({12'h380, 8'hFF});
    exp_wr_q.push_back({12'h381, 8'h80});
    run(12'h300, 12'h380, 2, 4, 2, 2, 1'b0, 1'b0, 8, 2);

    mem[12'hFFF] = 8'h10; mem[12'h000] = 8'h7F; mem[12'h001] = 8'h81; mem[12'h002] = 8'h00;
    exp_rd_q.push_back(12'hFFF); exp_rd_q.push_back(12'h000);
    exp_rd_q.push_back(12'h001); exp_rd_q.push_back(12'h002);
    exp_wr_q.push_back({12'hFFF, 8'h7F});
    run(12'hFFF, 12'hFFF, 2, 2, 2, 2, 1'b0, 1'b0, 4, 1);

    for (int k = 0; k < 35; k++) mem[12'h400 + k] = 8'(k * 29 + 3);
    expect_pool(12'h400, 12'h500, 5, 7, 2, 3, 1'b1);
    run(12'h400, 12'h500, 5, 7, 2, 3, 1'b0, 1'b0, 24, 4);

    run(12'h100, 12'h200, 4, 4, 0, 2, 1'b1, 1'b0, 0, 0);
    run(12'h100, 12'h200, 4, 4, 5, 2, 1'b1, 1'b0, 0, 0);
    run(12'h100, 12'h200, 2, 2, 2, 3, 1'b1, 1'b0, 0, 0);

    stall_en = 1'b1;
    expect_basic();
    run(12'h100, 12'h200, 4, 4, 2, 2, 1'b0, 1'b1, 16, 4);
    expect_pool(12'h400, 12'h500, 5, 7, 2, 3, 1'b1);
    run(12'h400, 12'h500, 5, 7, 2, 3, 1'b0, 1'b0, 24, 4);

    expect_basic();
    issue_start(12'h100, 12'h200, 4, 4, 2, 2);
    repeat (6) @(negedge clk);
    d0 = n_done;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", {cnn_sw_busy_ind, pool_done, pool_err, rd_req, wr_req}, 0);
    chk("midrst_addr", {rd_addr, wr_addr}, 0);
    chk("midrst_wdata", wr_data, 0);
    exp_rd_q.delete();
    exp_wr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_no_done", n_done - d0, 0);
    chk("midrst_quiet", {rd_req, wr_req, cnn_sw_busy_ind}, 0);
    expect_basic();
    run(12'h100, 12'h200, 4, 4, 2, 2, 1'b0, 1'b0, 16, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pool_ctrl.md
Name: pool_ctrl

Overview:
- Sequencer for the pooling engine. Walks an M×N int8 matrix in memory with non-overlapping P×Q max-pool windows (stride equals window).
- Issues one byte read per window element and tracks the running signed max. Writes one result byte per window.
- Sits between the software config registers and the shared memory read/write ports. Drives busy/done back to software.

Parameters:
- ADDR_WIDTH, 12, byte address width for both memory ports.
- DIM_W, 6, width of the matrix dimension fields (M, N up to 63).
- WIN_W, 3, width of the window dimension fields (P, Q up to 7).
- DATA_W, 8, element width (signed).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- sw_pool_start  in  1  one-cycle start pulse
- sw_cnn_pool_rd_addr  in  ADDR_WIDTH  matrix base address
- sw_pool_wr_addr  in  ADDR_WIDTH  result base address
- sw_cnn_pool_rd_m  in  DIM_W  matrix rows M
- sw_cnn_pool_rd_n  in  DIM_W  matrix columns N
- sw_pool_m  in  WIN_W  window rows P
- sw_pool_n  in  WIN_W  window columns Q
- cnn_sw_busy_ind  out  1  1 = operation in progress
- pool_done  out  1  one-cycle pulse at completion
- pool_err  out  1  sticky until next accepted start; illegal config
- rd_req  out  1  read request
- rd_addr  out  ADDR_WIDTH  read byte address
- rd_gnt  in  1  read request accepted this cycle
- rd_valid  in  1  read data valid (one per granted request, in order)
- rd_data  in  DATA_W  read data
- wr_req  out  1  write request
- wr_addr  out  ADDR_WIDTH  write byte address
- wr_data  out  DATA_W  write data
- wr_gnt  in  1  write accepted this cycle

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, FSM to IDLE, counters cleared. A reset mid-operation aborts with no done pulse and no further requests.
- Config latching:
  - sw_pool_start is sampled only in IDLE. On start, all sw_* inputs are latched and pool_err is cleared.
  - Start while busy is ignored. sw_* changes after start have no effect.
- Illegal config: P=0, Q=0, P>M, or Q>N. Result: pool_err=1 and pool_done pulse in the cycle after start. No memory traffic; busy is never asserted.
- Output grid: OR=floor(M/P), OC=floor(N/Q). Trailing rows and columns not covered by a full window are ignored.
- FSM states:
  - IDLE: on a legal start go to RD_REQ; busy=1 from the next cycle.
  - RD_REQ: rd_req=1 with rd_addr held stable until rd_gnt. On gnt go to RD_WAIT. At most one outstanding read.
  - RD_WAIT: wait for rd_valid and update the running max.
    - First element of a window loads the max unconditionally.
    - Later elements replace it if rd_data > max (signed compare). Ties keep the stored value.
    - If more window elements remain, go to RD_REQ; else go to WR_REQ.
  - WR_REQ: wr_req=1, wr_data=max, wr_addr=wr_base + r*OC + c, all held until wr_gnt.
    - On gnt, if more windows remain go to RD_REQ; else go to DONE.
  - DONE: pool_done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- rd_req and rd_gnt may both be high in the first request cycle. Zero-wait grant gives a 1-cycle RD_REQ.
- rd_valid may arrive the cycle after gnt at the earliest. rd_valid outside RD_WAIT is ignored.
- Traversal order: windows row-major (r, then c). Inside a window, elements row-major (i, then j).
  - Element address = rd_base + (r*P+i)*N + c*Q + j.
  - Computed incrementally with row/column pointer registers (adds only, no multipliers).
- Address arithmetic is modulo 2^ADDR_WIDTH (wrap-around, no error).
- Minimum cycles per window: P*Q*2 for reads plus 1 for the write.

Decomposition:
- Package pool_pkg holds:
  - FSM state enum pool_ctrl_state_e (IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE).
  - Width localparams DIM_W, WIN_W, DATA_W.
  - Typedef pool_cfg_t, the latched config struct.
- One natural sub-module: pool_addr_gen. It holds the r/c/i/j counters and the incremental read/write address pointers. It exposes step_elem, step_win, last_elem and last_win.

Test Plan:
- Basic 4×4, P=Q=2, base 0x100, wr 0x200, values 0..15, zero-wait grants -> rd_addr sequence 100,101,104,105,… The four writes are (200,5), (201,7), (202,13), (203,15). pool_done fires once and busy is high throughout.
- Signed values: 2×2 window holding {-5,-1,-128,-3} -> wr_data=0xFF (-1). Window of all -128 -> 0x80.
- Non-divisible 5×7, P=2, Q=3 -> OR=2, OC=2. Exactly 24 reads and 4 writes. Row 4 and column 6 are never addressed.
- Backpressure: random rd_gnt/wr_gnt stalls (0–5 cycles) and rd_valid delays -> addresses and data held stable while ungranted. Results are identical to the zero-wait run.
- Illegal config P=0 and P=5>M=4 -> pool_err=1, pool_done 1 cycle after start, no rd_req/wr_req, busy stays 0.
- Start while busy is ignored (same results as an undisturbed run). rst_n low mid-window -> all outputs 0 next cycle. A new start after reset completes correctly.
